// File: rtl/pcm_sched_if.sv
// Requester and DAC-FIFO handshake bundle for pcm_sched.
// The slave modport is the scheduler; the master side owns the requesters and the FIFO.
interface pcm_sched_if #(
  parameter int unsigned NUM_CH = 4
) ();
  logic [NUM_CH-1:0]   ch_valid;
  logic [8*NUM_CH-1:0] ch_data;
  logic [NUM_CH-1:0]   ch_ready;
  logic                fifo_full;
  logic                pcm_we;
  logic [7:0]          pcm_o;

  modport master (
    output ch_valid,
    output ch_data,
    output fifo_full,
    input  ch_ready,
    input  pcm_we,
    input  pcm_o
  );

  modport slave (
    input  ch_valid,
    input  ch_data,
    input  fifo_full,
    output ch_ready,
    output pcm_we,
    output pcm_o
  );
endinterface

// File: rtl/pcm_sched.sv
// PCM sample scheduler ahead of the PWM DAC FIFO: round-robin forwarding of single samples
// (ARB) or saturating mix of one sample per enabled channel (MIX).
module pcm_sched #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned MIX_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset,
  pcm_sched_if.slave        bus,
  input  logic              cfg_mix,
  input  logic [NUM_CH-1:0] cfg_mask,
  output logic [15:0]       sat_cnt,
  output logic [15:0]       underrun_cnt
);

  localparam int unsigned PtrW = $clog2(NUM_CH);
  localparam int unsigned SumW = 9 + $clog2(NUM_CH);
  localparam int unsigned TmrW = $clog2(MIX_TIMEOUT);
  localparam logic signed [SumW-1:0] SumMax = 127;
  localparam logic signed [SumW-1:0] SumMin = -128;

  typedef enum logic [1:0] {StIdle, StGrant, StCollect, StEmit} state_e;

  state_e                 state_q;
  logic [PtrW-1:0]        rr_ptr_q;
  logic [NUM_CH-1:0]      mask_q;
  logic [NUM_CH-1:0]      got_q;
  logic signed [SumW-1:0] sum_q;
  logic [TmrW-1:0]        timer_q;
  logic [7:0]             pcm_q;
  logic [15:0]            sat_q;
  logic [15:0]            und_q;

  logic                   grant_vld;
  logic [PtrW-1:0]        grant_idx;
  logic [7:0]             grant_data;
  logic [NUM_CH-1:0]      ready;
  logic [NUM_CH-1:0]      xfer;
  logic [NUM_CH-1:0]      got_upd;
  logic signed [SumW-1:0] sum_upd;
  logic [7:0]             mix_res;
  logic                   mix_clip;
  logic                   mix_done;
  logic                   mix_tmo;
  logic [7:0]             d;
  int                     idx;

  always_comb begin
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_data = 8'h00;
    idx        = 0;
    // Search starts one past the last winner and wraps.
    for (int k = 1; k <= int'(NUM_CH); k++) begin
      idx = (int'(rr_ptr_q) + k) % int'(NUM_CH);
      if (!grant_vld && mask_q[idx] && bus.ch_valid[idx]) begin
        grant_vld  = 1'b1;
        grant_idx  = PtrW'(idx);
        grant_data = bus.ch_data[8*idx +: 8];
      end
    end

    ready = '0;
    case (state_q)
      StGrant:   if (grant_vld) ready[grant_idx] = 1'b1;
      StCollect: ready = mask_q & ~got_q;
      default:   ready = '0;
    endcase
    xfer = ready & bus.ch_valid;

    // Offset-binary to two's complement is just an MSB flip, then sign-extend.
    sum_upd = sum_q;
    d       = 8'h00;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      d = bus.ch_data[8*i +: 8];
      if (xfer[i]) sum_upd = sum_upd + {{(SumW-8){~d[7]}}, ~d[7], d[6:0]};
    end
    got_upd  = got_q | xfer;
    mix_done = (got_upd == mask_q);
    mix_tmo  = (timer_q == TmrW'(MIX_TIMEOUT - 1));

    mix_clip = 1'b1;
    if (sum_upd > SumMax)      mix_res = 8'hFF;
    else if (sum_upd < SumMin) mix_res = 8'h00;
    else begin
      mix_res  = {~sum_upd[7], sum_upd[6:0]};
      mix_clip = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      rr_ptr_q <= PtrW'(NUM_CH - 1);
      mask_q   <= '0;
      got_q    <= '0;
      sum_q    <= '0;
      timer_q  <= '0;
      pcm_q    <= 8'h80;
      sat_q    <= '0;
      und_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          mask_q <= cfg_mask;
          if (!bus.fifo_full && (cfg_mask != '0)) begin
            if (cfg_mix) begin
              state_q <= StCollect;
              got_q   <= '0;
              sum_q   <= '0;
              timer_q <= '0;
            end else begin
              state_q <= StGrant;
            end
          end
        end
        StGrant: begin
          if (grant_vld) begin
            pcm_q    <= grant_data;
            rr_ptr_q <= grant_idx;
            state_q  <= StEmit;
          end
        end
        StCollect: begin
          got_q   <= got_upd;
          sum_q   <= sum_upd;
          timer_q <= timer_q + 1'b1;
          if (mix_done || mix_tmo) begin
            pcm_q   <= mix_res;
            state_q <= StEmit;
            if (mix_clip && sat_q != 16'hFFFF) sat_q <= sat_q + 16'd1;
            // Completion in the timeout cycle is not an underrun.
            if (!mix_done && und_q != 16'hFFFF) und_q <= und_q + 16'd1;
          end
        end
        StEmit: begin
          if (!bus.fifo_full) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ch_ready = ready;
  assign bus.pcm_we   = (state_q == StEmit) && !bus.fifo_full;
  assign bus.pcm_o    = pcm_q;
  assign sat_cnt      = sat_q;
  assign underrun_cnt = und_q;

endmodule

// File: tb/tb_pcm_sched.sv
// Directed bench for pcm_sched: ARB ordering and spacing, masking, MIX saturation,
// collection timeout, FIFO back-pressure and mid-collection reset.
module tb_pcm_sched;
  localparam int unsigned NCh = 4;

  logic           clk;
  logic           reset;
  logic           cfg_mix;
  logic [NCh-1:0] cfg_mask;
  logic [15:0]    sat_cnt;
  logic [15:0]    underrun_cnt;

  int n_vec;
  int n_err;
  int cyc_cnt;
  int we_cnt;
  int ready_cnt;
  int masked_ready;

  pcm_sched_if #(.NUM_CH(NCh)) bus ();

  pcm_sched #(
    .NUM_CH      (NCh),
    .MIX_TIMEOUT (16)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .cfg_mix      (cfg_mix),
    .cfg_mask     (cfg_mask),
    .sat_cnt      (sat_cnt),
    .underrun_cnt (underrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (bus.pcm_we === 1'b1) we_cnt <= we_cnt + 1;
    if (bus.ch_ready != '0) ready_cnt <= ready_cnt + 1;
    if ((bus.ch_ready & ~cfg_mask) != '0) masked_ready <= masked_ready + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advances on negedges until pcm_we is seen, bounded.
  task automatic wait_we(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (bus.pcm_we !== 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (bus.pcm_we !== 1'b1) check_eq({tag, "_timeout"}, 32'(bus.pcm_we), 32'd1);
  endtask

  initial begin
    int last;
    int w0;
    int r0;
    int t0;
    logic [7:0] arb_exp [5];
    arb_exp[0] = 8'h10; arb_exp[1] = 8'h20; arb_exp[2] = 8'h30;
    arb_exp[3] = 8'h40; arb_exp[4] = 8'h10;

    n_vec = 0; n_err = 0; cyc_cnt = 0; we_cnt = 0; ready_cnt = 0; masked_ready = 0;
    last = 0;
    reset        = 1'b1;
    cfg_mix      = 1'b0;
    cfg_mask     = 4'hF;
    bus.ch_valid = 4'hF;
    bus.ch_data  = 32'h40302010;
    bus.fifo_full = 1'b0;
    repeat (3) @(negedge clk);

    check_eq("rst_pcm_o", 32'(bus.pcm_o), 32'h80);
    check_eq("rst_pcm_we", 32'(bus.pcm_we), 32'd0);
    check_eq("rst_ready", 32'(bus.ch_ready), 32'd0);
    check_eq("rst_sat", 32'(sat_cnt), 32'd0);
    check_eq("rst_und", 32'(underrun_cnt), 32'd0);

    // ARB, all valid: channel 0 first, then rotate, one push per 3 cycles.
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_we("arb_we", 20);
      check_eq($sformatf("arb_data%0d", i), 32'(bus.pcm_o), 32'(arb_exp[i]));
      if (i > 0) check_eq($sformatf("arb_gap%0d", i), 32'(cyc_cnt - last), 32'd3);
      last = cyc_cnt;
      @(negedge clk);
    end

    // Mask of zero: nothing granted, nothing pushed.
    cfg_mask = 4'h0;
    w0 = we_cnt; r0 = ready_cnt;
    repeat (10) @(negedge clk);
    check_eq("mask0_we", 32'(we_cnt - w0), 32'd0);
    check_eq("mask0_ready", 32'(ready_cnt - r0), 32'd0);

    cfg_mask = 4'hF;
    bus.ch_valid = 4'b0100;
    wait_we("ch2_we", 20);
    check_eq("ch2_data", 32'(bus.pcm_o), 32'h30);
    @(negedge clk);
    bus.ch_valid = 4'b0010;
    wait_we("ch1_we", 20);
    check_eq("ch1_data", 32'(bus.pcm_o), 32'h20);
    @(negedge clk);
    // Channel 2 valid but masked off; only channel 1 may be granted.
    cfg_mask = 4'b1011;
    bus.ch_valid = 4'b0110;
    wait_we("msk_we", 20);
    check_eq("msk_data", 32'(bus.pcm_o), 32'h20);
    @(negedge clk);

    // MIX, two channels: in range, clip high, clip low.
    cfg_mix = 1'b1;
    cfg_mask = 4'b0011;
    bus.ch_valid = 4'b0011;
    bus.ch_data = 32'h0000A0C0;
    wait_we("mix1_we", 20);
    check_eq("mix1_data", 32'(bus.pcm_o), 32'hE0);
    check_eq("mix1_sat", 32'(sat_cnt), 32'd0);
    @(negedge clk);
    bus.ch_data = 32'h0000F0FF;
    wait_we("mix2_we", 20);
    check_eq("mix2_data", 32'(bus.pcm_o), 32'hFF);
    check_eq("mix2_sat", 32'(sat_cnt), 32'd1);
    @(negedge clk);
    bus.ch_data = 32'h00001000;
    wait_we("mix3_we", 20);
    check_eq("mix3_data", 32'(bus.pcm_o), 32'h00);
    check_eq("mix3_sat", 32'(sat_cnt), 32'd2);
    check_eq("mix3_und", 32'(underrun_cnt), 32'd0);
    @(negedge clk);

    // Timeout: only channel 0 supplies; 1 entry cycle + 16 collect cycles.
    bus.ch_valid = 4'b0001;
    bus.ch_data = 32'h00000090;
    t0 = cyc_cnt;
    wait_we("tmo_we", 40);
    check_eq("tmo_cycles", 32'(cyc_cnt - t0), 32'd17);
    check_eq("tmo_data", 32'(bus.pcm_o), 32'h90);
    check_eq("tmo_und", 32'(underrun_cnt), 32'd1);
    check_eq("tmo_sat", 32'(sat_cnt), 32'd2);
    @(negedge clk);

    // FIFO full held through EMIT.
    cfg_mix = 1'b0;
    cfg_mask = 4'hF;
    bus.ch_valid = 4'b0001;
    bus.ch_data = 32'h0000A55A;
    @(negedge clk);
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq($sformatf("full_we%0d", i), 32'(bus.pcm_we), 32'd0);
      check_eq($sformatf("full_pcm%0d", i), 32'(bus.pcm_o), 32'h5A);
    end
    w0 = we_cnt;
    bus.fifo_full = 1'b0;
    bus.ch_valid = 4'b0000;
    @(negedge clk);
    check_eq("full_push", 32'(we_cnt - w0), 32'd1);
    // Full while idle: no handshake offered.
    bus.fifo_full = 1'b1;
    bus.ch_valid = 4'hF;
    w0 = we_cnt; r0 = ready_cnt;
    repeat (6) @(negedge clk);
    check_eq("idle_full_ready", 32'(ready_cnt - r0), 32'd0);
    check_eq("idle_full_we", 32'(we_cnt - w0), 32'd0);
    bus.fifo_full = 1'b0;
    wait_we("after_full_we", 20);
    check_eq("after_full_data", 32'(bus.pcm_o), 32'hA5);
    @(negedge clk);

    // Reset with half a mix collected; the next mix must start clean.
    cfg_mix = 1'b1;
    cfg_mask = 4'b0011;
    bus.ch_valid = 4'b0001;
    bus.ch_data = 32'h000000F0;
    repeat (2) @(negedge clk);
    w0 = we_cnt;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("abort_push", 32'(we_cnt - w0), 32'd0);
    check_eq("abort_pcm_o", 32'(bus.pcm_o), 32'h80);
    check_eq("abort_sat", 32'(sat_cnt), 32'd0);
    check_eq("abort_und", 32'(underrun_cnt), 32'd0);
    bus.ch_valid = 4'b0011;
    bus.ch_data = 32'h00008890;
    wait_we("post_rst_we", 20);
    check_eq("post_rst_data", 32'(bus.pcm_o), 32'h98);
    check_eq("post_rst_sat", 32'(sat_cnt), 32'd0);
    @(negedge clk);

    check_eq("masked_ready", 32'(masked_ready), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pcm_sched.md
Name: pcm_sched

Overview:
- Sample scheduler placed in front of the audio PWM DAC's sample FIFO.
- Takes 8-bit offset-binary PCM (0x80 = silence) from NUM_CH independent requesters, such as CPU MMIO writers or a tone generator.
- Either round-robin forwards individual samples (ARB mode) or mixes one sample per enabled channel into a single saturated sample (MIX mode).
- Writes results to the FIFO via a single-cycle write strobe, honouring the FIFO's full flag.

Parameters:
- NUM_CH, 4: number of requester channels (2..8).
- MIX_TIMEOUT, 4096: cycles to wait in MIX collection before missing channels are treated as silence.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- ch_valid  in  NUM_CH  per-channel sample valid.
- ch_data  in  8*NUM_CH  per-channel sample; channel i occupies bits [8i+7:8i].
- ch_ready  out  NUM_CH  per-channel accept; a transfer occurs when valid and ready are both high.
- cfg_mix  in  1  0 = ARB mode, 1 = MIX mode.
- cfg_mask  in  NUM_CH  channel enable mask.
- fifo_full  in  1  full flag from the DAC sample FIFO.
- pcm_we  out  1  one-cycle FIFO push strobe.
- pcm_o  out  8  sample pushed with pcm_we.
- sat_cnt  out  16  number of MIX results that were clipped; saturates at 0xFFFF.
- underrun_cnt  out  16  number of MIX timeouts; saturates at 0xFFFF.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; rr_ptr=NUM_CH-1, so channel 0 has first priority.
  - got=0; sum=0; timer=0; pcm_we=0; pcm_o=0x80; ch_ready=0; sat_cnt=0; underrun_cnt=0.
  - Reset mid-operation discards any captured sample or partial sum; nothing is pushed.
- States: IDLE, GRANT, COLLECT, EMIT.
- IDLE:
  - cfg_mix and cfg_mask are latched into mode_r/mask_r only here.
  - Stay in IDLE if fifo_full=1 or cfg_mask=0.
  - Otherwise go to GRANT if cfg_mix=0, or to COLLECT if cfg_mix=1.
  - On entering COLLECT, clear got, sum and timer.
- GRANT (ARB mode):
  - grant = first i with mask_r[i] & ch_valid[i], searching from (rr_ptr+1) mod NUM_CH upward and wrapping.
  - ch_ready is combinational and one-hot on grant; all zero if no channel is valid.
  - With no valid channel, remain in GRANT.
  - On a transfer: capture ch_data[grant] into pcm_o, set rr_ptr=grant, go to EMIT.
- COLLECT (MIX mode):
  - ch_ready[i] = mask_r[i] & ~got[i]; several channels may transfer in the same cycle.
  - Each transferring channel sets got[i] and adds (data-128) as signed to sum.
  - sum width is 9+clog2(NUM_CH) bits, so it cannot overflow.
  - timer increments each cycle spent in COLLECT.
  - When (got | transfers this cycle) == mask_r, compute the result from the updated sum and go to EMIT.
  - If timer reaches MIX_TIMEOUT-1 first:
    - Take this cycle's transfers.
    - Treat the remaining channels as 0 (silence).
    - Increment underrun_cnt.
    - Go to EMIT.
  - Result = clamp(sum, -128, +127) + 128. If clamping changed the value, increment sat_cnt.
- EMIT:
  - pcm_we = (state==EMIT) & ~fifo_full.
  - Stay in EMIT while fifo_full=1, holding pcm_o stable.
  - Return to IDLE the cycle after pcm_we=1.
- Throughput: ARB mode achieves 1 sample per 3 cycles when valid is held high. Latency from transfer to pcm_we is 1 cycle when the FIFO is not full.
- Outside EMIT, pcm_we=0; pcm_o holds its last value.
- ch_ready=0 in IDLE and EMIT.
- A change to cfg_* mid-transaction has no effect until the next IDLE.

Test Plan:
- Reset, then ARB mode with mask=0xF and all ch_valid=1 carrying data 0x10/0x20/0x30/0x40 -> pcm_o sequence 0x10,0x20,0x30,0x40,0x10; each pcm_we spaced exactly 3 cycles apart.
- ARB mode with only channel 2 valid, then channel 1 valid -> grants go to 2 then 1; ch_ready is never asserted for a masked channel; no grants while mask=0.
- MIX mode, mask=0x3, samples 0xC0 and 0xA0 -> pcm_o=0xE0 and sat_cnt=0. Then samples 0xFF and 0xF0 -> pcm_o=0xFF and sat_cnt=1. Then 0x00 and 0x10 -> pcm_o=0x00 and sat_cnt=2.
- MIX mode with MIX_TIMEOUT=16, mask=0x3, only channel 0 supplies 0x90 -> pcm_we after 16 collect cycles with pcm_o=0x90 and underrun_cnt=1.
- Hold fifo_full=1 during EMIT for 5 cycles -> pcm_we stays low and pcm_o stays stable; a single push occurs the cycle after fifo_full falls. With fifo_full=1 in IDLE, no ch_ready is asserted.
- Assert reset during COLLECT with 1 of 2 samples received -> no push. After reset, a full MIX transaction produces a correct sum, with no residue from the aborted one.
